mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory port of the multicycle core (mcp) between two requesters: the core (fetch/lw/sw) and the program loader/DMA.
- Round-robin grant, one access in flight, registered request capture, variable-latency memory handshake via mem_ready_i.
- Sits between the core datapath memory interface and the memory model/BRAM wrapper.

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single unified instruction/data memory port
// of the multicycle core between the core and the program loader/DMA.
// Round-robin grant, one access in flight, operands captured at grant,
// variable-latency completion through mem_ready_i.
//
// Ports:
//   clk_i, reset_ni          clock, asynchronous active-low reset
//   core_req/we/addr/wdata_i core request side, held until core_done_o
//   core_done_o/rdata_o      one-cycle completion pulse and read data
//   ldr_req/we/addr/wdata_i  loader request side, held until ldr_done_o
//   ldr_done_o/rdata_o       one-cycle completion pulse and read data
//   mem_req/we/addr/wdata_o  memory access strobe and operands
//   mem_ready_i, mem_rdata_i memory completion and read data
//   owner_o, busy_o          current owner (0 core, 1 loader), not idle
//   err_o, timeout_flag_o    aborted access, sticky abort indicator
//
// Build option: define MEM_ARB_TIMEOUT_EN to abort an access that sees no
// mem_ready_i for TIMEOUT_CYCLES cycles; otherwise ACCESS waits forever.
module mem_port_arbiter #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_wdata_i,
    output logic          core_done_o,
    output logic [DW-1:0] core_rdata_o,
    input  logic          ldr_req_i,
    input  logic          ldr_we_i,
    input  logic [AW-1:0] ldr_addr_i,
    input  logic [DW-1:0] ldr_wdata_i,
    output logic          ldr_done_o,
    output logic [DW-1:0] ldr_rdata_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ready_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          owner_o,
    output logic          busy_o,
    output logic          err_o,
    output logic          timeout_flag_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e        state_q;
    logic          last_q;
    logic          owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          core_done_q;
    logic          ldr_done_q;
    logic [DW-1:0] core_rdata_q;
    logic [DW-1:0] ldr_rdata_q;
    logic          err_q;
    logic          tflag_q;

    logic          pick_ldr;
    logic          abort;
    logic          in_access;
    logic [DW-1:0] rd_capture;

    // On a tie the side that was not served last wins.
    assign pick_ldr   = ldr_req_i & (~core_req_i | ~last_q);
    assign in_access  = (state_q == ACCESS);
    // Writes complete with zero read data; an abort also returns zero.
    assign rd_capture = (mem_ready_i & ~we_q) ? mem_rdata_i : '0;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // A ready arriving on the limit cycle still completes normally.
    assign abort = in_access & ~mem_ready_i & (cnt_q == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else if (!in_access) begin
            cnt_q <= '0;
        end else if (!mem_ready_i && !abort) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYCLES;
    assign abort          = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_done_q  <= 1'b0;
            ldr_done_q   <= 1'b0;
            core_rdata_q <= '0;
            ldr_rdata_q  <= '0;
            err_q        <= 1'b0;
            tflag_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (core_req_i || ldr_req_i) begin
                        owner_q <= pick_ldr;
                        we_q    <= pick_ldr ? ldr_we_i    : core_we_i;
                        addr_q  <= pick_ldr ? ldr_addr_i  : core_addr_i;
                        wdata_q <= pick_ldr ? ldr_wdata_i : core_wdata_i;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ready_i || abort) begin
                        core_done_q <= ~owner_q;
                        ldr_done_q  <= owner_q;
                        if (owner_q) begin
                            ldr_rdata_q <= rd_capture;
                        end else begin
                            core_rdata_q <= rd_capture;
                        end
                        err_q <= abort;
                        if (abort) begin
                            tflag_q <= 1'b1;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    core_done_q  <= 1'b0;
                    ldr_done_q   <= 1'b0;
                    core_rdata_q <= '0;
                    ldr_rdata_q  <= '0;
                    err_q        <= 1'b0;
                    last_q       <= owner_q;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_o      = in_access;
    assign mem_we_o       = in_access & we_q;
    assign mem_addr_o     = in_access ? addr_q  : '0;
    assign mem_wdata_o    = in_access ? wdata_q : '0;
    assign core_done_o    = core_done_q;
    assign core_rdata_o   = core_rdata_q;
    assign ldr_done_o     = ldr_done_q;
    assign ldr_rdata_o    = ldr_rdata_q;
    assign owner_o        = owner_q;
    assign busy_o         = (state_q != IDLE);
    assign err_o          = err_q;
    assign timeout_flag_o = tflag_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a
// behavioural arbitration model, random requesters and a latency memory.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        core_req_i, core_we_i;
    logic [31:0] core_addr_i, core_wdata_i;
    logic        core_done_o;
    logic [31:0] core_rdata_o;
    logic        ldr_req_i, ldr_we_i;
    logic [31:0] ldr_addr_i, ldr_wdata_i;
    logic        ldr_done_o;
    logic [31:0] ldr_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;
    logic        owner_o, busy_o, err_o, timeout_flag_o;

    mem_port_arbiter #(
        .AW(32), .DW(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .core_req_i(core_req_i), .core_we_i(core_we_i),
        .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_done_o(core_done_o), .core_rdata_o(core_rdata_o),
        .ldr_req_i(ldr_req_i), .ldr_we_i(ldr_we_i),
        .ldr_addr_i(ldr_addr_i), .ldr_wdata_i(ldr_wdata_i),
        .ldr_done_o(ldr_done_o), .ldr_rdata_o(ldr_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .owner_o(owner_o), .busy_o(busy_o),
        .err_o(err_o), .timeout_flag_o(timeout_flag_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t core_q[$];
    txn_t ldr_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat_fixed = 0;
    int lat_used = 0;
    int last_done_cyc = -1;
    bit core_pend = 0, ldr_pend = 0;
    bit in_reset = 1;
    bit last_served = 1;
    bit expect_err = 0;
    bit tflag_exp = 0;
    bit gap_chk = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] memfun(logic [31:0] a);
        return a ^ 32'h2008_0015;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_side(bit s, bit req, bit we,
                            logic [31:0] a, logic [31:0] d);
        if (s) begin
            ldr_req_i = req; ldr_we_i = we;
            ldr_addr_i = a;  ldr_wdata_i = d;
            ldr_pend = req;
        end else begin
            core_req_i = req; core_we_i = we;
            core_addr_i = a;  core_wdata_i = d;
            core_pend = req;
        end
    endtask

    task automatic issue(bit s, bit we, logic [31:0] a, logic [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        t.rdata = we ? 32'h0 : memfun(a);
        if (s) ldr_q.push_back(t);
        else core_q.push_back(t);
        set_side(s, 1'b1, we, a, d);
    endtask

    task automatic wait_done(bit s);
        int n;
        n = 0;
        forever begin
            @(negedge clk_i);
            if (s ? ldr_done_o : core_done_o) break;
            n++;
            if (n > 300) begin
                checks++; errors++;
                $display("FAIL wait_done side %0d: no done in 300 cycles, one required", s);
                break;
            end
        end
    endtask

    task automatic drop(bit s);
        @(posedge clk_i); #1;
        set_side(s, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic drive(bit s, int n, bit hold, int maxgap);
        for (int i = 0; i < n; i++) begin
            bit we;
            logic [31:0] a, d;
            we = 1'($urandom_range(0, 1));
            a = $urandom;
            d = $urandom;
            issue(s, we, a, d);
            wait_done(s);
            @(posedge clk_i); #1;
            if (!hold || i == n - 1) begin
                set_side(s, 1'b0, 1'b0, 32'h0, 32'h0);
                repeat ($urandom_range(0, maxgap)) begin
                    @(posedge clk_i); #1;
                end
            end
        end
    endtask

    task automatic hard_reset();
        in_reset = 1;
        reset_ni = 1'b0;
        core_q.delete(); ldr_q.delete();
        set_side(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_side(1, 1'b0, 1'b0, 32'h0, 32'h0);
        last_served = 1;
        tflag_exp = 0;
        repeat (2) @(posedge clk_i);
        #1 reset_ni = 1'b1;
        @(posedge clk_i); #1;
        in_reset = 0;
    endtask

    // Memory model: fixed or random wait states, data is a pure function
    // of the address so the scoreboard can predict every read.
    initial begin
        int wcnt;
        int lat;
        mem_ready_i = 1'b0;
        mem_rdata_i = 32'h0;
        wcnt = -1;
        lat = 0;
        forever begin
            @(posedge clk_i); #1;
            if (mem_req_o) begin
                if (wcnt < 0) begin
                    lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 5));
                    lat_used = lat;
                    wcnt = 0;
                end
                if (wcnt == lat) begin
                    mem_ready_i = 1'b1;
                    mem_rdata_i = memfun(mem_addr_o);
                end else begin
                    mem_ready_i = 1'b0;
                    mem_rdata_i = $urandom;
                end
                wcnt++;
            end else begin
                mem_ready_i = 1'b0;
                mem_rdata_i = $urandom;
                wcnt = -1;
            end
        end
    end

    // Monitor: predicts each grant from who was pending at the arbitration
    // edge and round-robin history, then checks bus, done and data.
    initial begin
        bit sc, sl, prev_req, cur_own, active;
        txn_t cur;
        int rise_cyc;
        prev_req = 0; active = 0; cur_own = 0; rise_cyc = 0;
        cur.we = 0; cur.addr = 0; cur.wdata = 0; cur.rdata = 0;
        forever begin
            @(posedge clk_i);
            sc = core_pend;
            sl = ldr_pend;
            @(negedge clk_i);
            if (in_reset) begin
                prev_req = 0;
                active = 0;
                continue;
            end
            if (mem_req_o && !prev_req) begin
                if (!sc && !sl) begin
                    checks++; errors++;
                    $display("FAIL grant: access started with no pending request");
                end
                cur_own = (sc && sl) ? !last_served : sl;
                last_served = cur_own;
                chk("grant_owner", owner_o, cur_own);
                chk("grant_busy", busy_o, 1);
                if ((cur_own ? ldr_q.size() : core_q.size()) == 0) begin
                    checks++; errors++; active = 0;
                    $display("FAIL grant_txn: owner %0d has no queued txn", cur_own);
                end else begin
                    cur = cur_own ? ldr_q[0] : core_q[0];
                    active = 1;
                end
                rise_cyc = cyc;
            end
            if (mem_req_o && active) begin
                chk("mem_addr", mem_addr_o, cur.addr);
                chk("mem_we", mem_we_o, cur.we);
                chk("mem_wdata", mem_wdata_o, cur.wdata);
            end else if (!mem_req_o) begin
                chk("mem_addr_idle", mem_addr_o, 0);
                chk("mem_we_idle", mem_we_o, 0);
            end
            if (core_done_o || ldr_done_o) begin
                if (!active) begin
                    checks++; errors++;
                    $display("FAIL done: pulse with no access in flight");
                end else begin
                    if (expect_err) tflag_exp = 1;
                    chk("done_core", core_done_o, !cur_own);
                    chk("done_ldr", ldr_done_o, cur_own);
                    chk("rdata", cur_own ? ldr_rdata_o : core_rdata_o,
                        expect_err ? 32'h0 : cur.rdata);
                    chk("rdata_other", cur_own ? core_rdata_o : ldr_rdata_o, 0);
                    chk("err", err_o, expect_err);
                    if (!expect_err)
                        chk("latency", cyc - rise_cyc, lat_used + 1);
                    if (gap_chk && last_done_cyc >= 0)
                        chk("done_gap", cyc - last_done_cyc, 3);
                    last_done_cyc = cyc;
                    if (cur_own) void'(ldr_q.pop_front());
                    else void'(core_q.pop_front());
                    active = 0;
                end
            end else begin
                chk("core_rdata_idle", core_rdata_o, 0);
                chk("ldr_rdata_idle", ldr_rdata_o, 0);
                chk("err_idle", err_o, 0);
            end
            chk("tflag", timeout_flag_o, tflag_exp);
            prev_req = mem_req_o;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_ni = 1'b0;
        set_side(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_side(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_core_done", core_done_o, 0);
        chk("rst_ldr_done", ldr_done_o, 0);
        chk("rst_core_rdata", core_rdata_o, 0);
        chk("rst_ldr_rdata", ldr_rdata_o, 0);
        chk("rst_owner", owner_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_tflag", timeout_flag_o, 0);
        hard_reset();

        // Single core read, ready tied high.
        lat_fixed = 0;
        issue(0, 1'b0, 32'h0000_0010, 32'h0);
        @(negedge clk_i);
        chk("t1_c0_req", mem_req_o, 0);
        @(negedge clk_i);
        chk("t1_c1_req", mem_req_o, 1);
        chk("t1_c1_addr", mem_addr_o, 32'h10);
        chk("t1_c1_we", mem_we_o, 0);
        @(negedge clk_i);
        chk("t1_c2_done", core_done_o, 1);
        chk("t1_c2_rdata", core_rdata_o, 32'h2008_0005);
        chk("t1_c2_ldr_done", ldr_done_o, 0);
        drop(0);

        // Simultaneous requests from reset: core first, then loader write.
        hard_reset();
        issue(0, 1'b0, 32'h0000_0100, 32'h0);
        issue(1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("t2_first_owner", owner_o, 0);
        fork
            begin wait_done(0); drop(0); end
            begin wait_done(1); drop(1); end
        join

        // Saturated alternation, one done every 3 cycles.
        repeat (2) @(posedge clk_i);
        #1;
        gap_chk = 1;
        last_done_cyc = -1;
        fork
            drive(0, 3, 1, 0);
            drive(1, 3, 1, 0);
        join
        gap_chk = 0;

        // Slow memory; core address changes after capture.
        lat_fixed = 4;
        issue(0, 1'b0, 32'h0000_0200, 32'h0);
        for (int n = 0; n < 20 && !mem_req_o; n++) @(negedge clk_i);
        @(posedge clk_i); #1;
        core_addr_i = 32'hFFFF_0000;
        core_wdata_i = 32'h1234_5678;
        wait_done(0);
        drop(0);

        // Reset in the middle of an access.
        lat_fixed = 10;
        issue(0, 1'b0, 32'h0000_0300, 32'h0);
        for (int n = 0; n < 20 && !mem_req_o; n++) @(negedge clk_i);
        @(negedge clk_i);
        #2;
        in_reset = 1;
        reset_ni = 1'b0;
        #1;
        chk("t5_mem_req", mem_req_o, 0);
        chk("t5_busy", busy_o, 0);
        chk("t5_owner", owner_o, 0);
        chk("t5_mem_addr", mem_addr_o, 0);
        chk("t5_core_done", core_done_o, 0);
        @(negedge clk_i);
        chk("t5_no_done", core_done_o, 0);
        hard_reset();
        lat_fixed = 0;
        issue(0, 1'b0, 32'h0000_0500, 32'h0);
        issue(1, 1'b0, 32'h0000_0600, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("t5_tie_core", owner_o, 0);
        fork
            begin wait_done(0); drop(0); end
            begin wait_done(1); drop(1); end
        join

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: abort with err and zero data.
        lat_fixed = 50;
        expect_err = 1;
        issue(0, 1'b0, 32'h0000_0700, 32'h0);
        wait_done(0);
        drop(0);
        expect_err = 0;
`endif

        // Random traffic with random memory latency.
        lat_fixed = -1;
        fork
            drive(0, 30, 0, 4);
            drive(1, 30, 0, 4);
        join
        fork
            drive(0, 10, 1, 0);
            drive(1, 10, 0, 3);
        join

        repeat (4) @(negedge clk_i);
        chk("end_core_q_empty", core_q.size(), 0);
        chk("end_ldr_q_empty", ldr_q.size(), 0);
        chk("end_busy", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
